edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of monitored input channels (2..16).
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port signal, input, NREQ bits: monitored levels, already synchronous to CLK.
REQ-005 SHALL have port pos_en, input, NREQ bits: per-channel rising-edge capture enable.
REQ-006 SHALL have port neg_en, input, NREQ bits: per-channel falling-edge capture enable.
REQ-007 SHALL have port evt_valid, output, 1 bit: event offered to the consumer.
REQ-008 SHALL have port evt_ready, input, 1 bit: consumer accepts; handshake = evt_valid & evt_ready.
REQ-009 SHALL have port evt_id, output, $clog2(NREQ) bits: channel of the offered event.
REQ-010 SHALL have port evt_pol, output, 1 bit: 1 = rising edge, 0 = falling edge.
REQ-011 SHALL have port pending, output, NREQ bits: per-channel captured-but-unaccepted flag.
REQ-012 SHALL have port overflow, output, NREQ bits: sticky per-channel dropped-edge flag.
REQ-013 SHALL have port clr_ovf, input, 1 bit: single-cycle pulse that clears all overflow bits.

Function
REQ-014 SHALL register signal each cycle into signal_r; an edge on channel i is signal[i] != signal_r[i], with polarity signal[i].
REQ-015 SHALL ignore all edges in the first cycle after nRST deasserts (armed flag), so levels present at reset release never create events.
REQ-016 SHALL capture an edge only if the matching enable (pos_en or neg_en) is 1 in the sampling cycle; pending[i] and stored polarity update at that same clock edge.
REQ-017 SHALL, for an enabled edge on a channel whose pending is already set and not being accepted that cycle, drop the new edge, keep the stored polarity, and set overflow[i].
REQ-018 SHALL, for an enabled edge on a channel being accepted in the same cycle, capture the new edge as pending without overflow.
REQ-019 SHALL NOT cancel an existing pending event when its enable deasserts.
REQ-020 SHALL implement a two-state FSM: IDLE and OFFER.
REQ-021 SHALL, in IDLE with any pending bit set, select a channel round-robin starting at last_grant+1 (wrapping NREQ-1 to 0), register evt_id/evt_pol, and enter OFFER.
REQ-022 SHALL assert evt_valid only in OFFER and hold evt_id/evt_pol stable until the handshake.
REQ-023 SHALL, on handshake, clear pending[evt_id] (unless REQ-018 applies), set last_grant to evt_id, and return to IDLE.
REQ-024 SHALL give a latency of 2 cycles from an edge sampled at clock k to evt_valid high after clock k+1, with the FSM idle and no competing requests.
REQ-025 SHALL sustain at most one accepted event per 2 cycles, with a mandatory IDLE bubble.
REQ-026 SHALL give set priority over clr_ovf when both hit the same overflow bit in the same cycle.

Reset
REQ-027 SHALL, while nRST is low, force: evt_valid=0, evt_id=0, evt_pol=0, pending=0, overflow=0, signal_r=0, armed=0, last_grant=NREQ-1, FSM=IDLE.
REQ-028 SHALL, when reset is asserted mid-OFFER, drop the offered event immediately, with no handshake completed.

Structure
REQ-029 SHALL place the IDLE/OFFER state enum, the default NREQ, and the channel-index width function in package edge_event_arbiter_pkg.
REQ-030 SHALL implement REQ-014..REQ-019 in one sub-module, edge_capture (per-channel registered sample, armed gating, pending/polarity/overflow), instantiated once for the whole vector; arbitration and the FSM stay in the top module.

Verification
REQ-031 SHALL verify a single edge: ch2 rises with pos_en=4'b0100 and evt_ready=1 -> evt_valid is high 2 cycles later with evt_id=2, evt_pol=1 for exactly 1 cycle, and pending returns to 0.
REQ-032 SHALL verify round-robin: ch0, ch1 and ch3 rise in the same cycle with last_grant=3 and ready held high -> grant order is 0, 1, 3, each with evt_valid high on alternate cycles.
REQ-033 SHALL verify backpressure and overflow: ch1 rises, evt_ready=0 for 5 cycles, then ch1 falls with neg_en[1]=1 -> evt_pol stays 1, overflow[1]=1, and on ready only one event is delivered.
REQ-034 SHALL verify accept-plus-new-edge: ch0 falls in the handshake cycle of its earlier rising event -> a second event follows with evt_pol=0 and overflow[0]=0.
REQ-035 SHALL verify reset behaviour: signal=4'b1111 while nRST is low, then release -> no events; nRST pulsed low during OFFER -> evt_valid=0 immediately and pending=0.
REQ-036 SHALL verify clear collision: clr_ovf pulses in the same cycle as a new overflow on ch3 -> overflow=4'b1000 and all other overflow bits cleared.

Source files
------------

// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and helpers for the edge event arbiter.
package edge_event_arbiter_pkg;

  localparam int NREQ_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  function automatic int id_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Valid/ready event channel between the arbiter and its consumer.
interface edge_event_arbiter_if
  import edge_event_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
);

  logic                      evt_valid;
  logic                      evt_ready;
  logic [id_width(NREQ)-1:0] evt_id;
  logic                      evt_pol;

  modport master (output evt_valid, output evt_id, output evt_pol, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_pol, output evt_ready);

endinterface

// File: rtl/edge_capture.sv
// Per-channel edge detection with armed gating, pending/polarity storage and
// sticky overflow for edges that arrive while a channel is still pending.
module edge_capture
  import edge_event_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NREQ-1:0] signal,
  input  logic [NREQ-1:0] pos_en,
  input  logic [NREQ-1:0] neg_en,
  input  logic            clr_ovf,
  input  logic            accept,
  input  logic [IDW-1:0]  accept_id,
  output logic [NREQ-1:0] pending,
  output logic [NREQ-1:0] pol,
  output logic [NREQ-1:0] overflow
);

  logic [NREQ-1:0] signal_r;
  logic            armed;
  logic [NREQ-1:0] edge_det;
  logic [NREQ-1:0] cap;
  logic [NREQ-1:0] acc_vec;
  logic [NREQ-1:0] take;
  logic [NREQ-1:0] drop;

  assign edge_det = armed ? (signal ^ signal_r) : '0;
  assign cap      = edge_det & ((signal & pos_en) | (~signal & neg_en));
  assign acc_vec  = accept ? (NREQ'(1) << accept_id) : '0;
  // A channel being accepted this cycle is free to take a new edge.
  assign take     = cap & (~pending | acc_vec);
  assign drop     = cap & pending & ~acc_vec;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      signal_r <= '0;
      armed    <= 1'b0;
      pending  <= '0;
      pol      <= '0;
      overflow <= '0;
    end else begin
      signal_r <= signal;
      armed    <= 1'b1;
      pending  <= take | (pending & ~acc_vec);
      pol      <= (pol & ~take) | (signal & take);
      overflow <= drop | (clr_ovf ? '0 : overflow);
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Round-robin arbiter offering captured edge events over a valid/ready channel.
//   state | meaning
//   IDLE  | no event offered; picks next pending channel after last_grant
//   OFFER | evt_valid high, evt_id/evt_pol held until handshake
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NREQ-1:0]      signal,
  input  logic [NREQ-1:0]      pos_en,
  input  logic [NREQ-1:0]      neg_en,
  input  logic                 clr_ovf,
  output logic [NREQ-1:0]      pending,
  output logic [NREQ-1:0]      overflow,
  edge_event_arbiter_if.master evt
);

  localparam int         IDW   = id_width(NREQ);
  localparam logic [0:0] IDLE  = 1'(ST_IDLE);
  localparam logic [0:0] OFFER = 1'(ST_OFFER);

  logic [0:0]      state;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  id_r;
  logic            pol_r;
  logic [IDW-1:0]  sel;
  logic            found;
  logic [NREQ-1:0] pol;
  logic            accept;

  assign evt.evt_valid = (state == OFFER);
  assign evt.evt_id    = id_r;
  assign evt.evt_pol   = pol_r;
  assign accept        = (state == OFFER) & evt.evt_ready;

  edge_capture #(.NREQ(NREQ), .IDW(IDW)) u_capture (
    .CLK       (CLK),
    .nRST      (nRST),
    .signal    (signal),
    .pos_en    (pos_en),
    .neg_en    (neg_en),
    .clr_ovf   (clr_ovf),
    .accept    (accept),
    .accept_id (id_r),
    .pending   (pending),
    .pol       (pol),
    .overflow  (overflow)
  );

  // Search starts one past the last grant; k = NREQ lands back on last_grant.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && pending[(int'(last_grant) + k) % NREQ]) begin
        found = 1'b1;
        sel   = IDW'((int'(last_grant) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      id_r       <= '0;
      pol_r      <= 1'b0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            id_r  <= sel;
            pol_r <= pol[sel];
            state <= OFFER;
          end
        end
        default: begin
          if (evt.evt_ready) begin
            last_grant <= id_r;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: vector table plus corner sequences.
module tb_edge_event_arbiter;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [3:0] signal;
  logic [3:0] pos_en;
  logic [3:0] neg_en;
  logic       clr_ovf;
  logic [3:0] pending;
  logic [3:0] overflow;

  int n_tests = 0;
  int n_fail  = 0;

  edge_event_arbiter_if #(.NREQ(4)) evt_bus ();

  edge_event_arbiter #(.NREQ(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .signal   (signal),
    .pos_en   (pos_en),
    .neg_en   (neg_en),
    .clr_ovf  (clr_ovf),
    .pending  (pending),
    .overflow (overflow),
    .evt      (evt_bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] sig;
    logic [3:0] pos;
    logic [3:0] neg;
    logic       rdy;
    logic       exp_v;
    logic [1:0] exp_id;
    logic       exp_pol;
    logic [3:0] exp_pend;
    logic [3:0] exp_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset(input logic [3:0] sig);
    nRST              = 1'b0;
    signal            = sig;
    pos_en            = 4'b0000;
    neg_en            = 4'b0000;
    clr_ovf           = 1'b0;
    evt_bus.evt_ready = 1'b0;
    step();
    step();
    nRST = 1'b1;
    step();
  endtask

  task automatic add(input logic [3:0] sig, input logic [3:0] pos, input logic [3:0] neg,
                     input logic rdy, input logic v, input logic [1:0] id, input logic p,
                     input logic [3:0] pend, input logic [3:0] ovf);
    vec_t r;
    r.sig = sig; r.pos = pos; r.neg = neg; r.rdy = rdy;
    r.exp_v = v; r.exp_id = id; r.exp_pol = p; r.exp_pend = pend; r.exp_ovf = ovf;
    tbl.push_back(r);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      signal            = tbl[i].sig;
      pos_en            = tbl[i].pos;
      neg_en            = tbl[i].neg;
      evt_bus.evt_ready = tbl[i].rdy;
      step();
      chk($sformatf("row%0d valid", i), 32'(evt_bus.evt_valid), 32'(tbl[i].exp_v));
      chk($sformatf("row%0d id", i), 32'(evt_bus.evt_id), 32'(tbl[i].exp_id));
      chk($sformatf("row%0d pol", i), 32'(evt_bus.evt_pol), 32'(tbl[i].exp_pol));
      chk($sformatf("row%0d pending", i), 32'(pending), 32'(tbl[i].exp_pend));
      chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].exp_ovf));
    end
  endtask

  initial begin
    // single rising edge on ch2 (rows 0..4)
    add(4'b0100, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0100, 4'b0000);
    add(4'b0100, 4'b0100, 4'b0000, 1, 1, 2, 1, 4'b0100, 4'b0000);
    add(4'b0100, 4'b0100, 4'b0000, 1, 0, 2, 1, 4'b0000, 4'b0000);
    add(4'b0100, 4'b0100, 4'b0000, 1, 0, 2, 1, 4'b0000, 4'b0000);
    add(4'b0000, 4'b0100, 4'b0000, 1, 0, 2, 1, 4'b0000, 4'b0000);
    // round-robin ch0, ch1, ch3 from last_grant=3 (rows 5..12)
    add(4'b1011, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b1011, 4'b0000);
    add(4'b1011, 4'b1111, 4'b0000, 1, 1, 0, 1, 4'b1011, 4'b0000);
    add(4'b1011, 4'b1111, 4'b0000, 1, 0, 0, 1, 4'b1010, 4'b0000);
    add(4'b1011, 4'b1111, 4'b0000, 1, 1, 1, 1, 4'b1010, 4'b0000);
    add(4'b1011, 4'b1111, 4'b0000, 1, 0, 1, 1, 4'b1000, 4'b0000);
    add(4'b1011, 4'b1111, 4'b0000, 1, 1, 3, 1, 4'b1000, 4'b0000);
    add(4'b1011, 4'b1111, 4'b0000, 1, 0, 3, 1, 4'b0000, 4'b0000);
    add(4'b1011, 4'b1111, 4'b0000, 1, 0, 3, 1, 4'b0000, 4'b0000);

    nRST              = 1'b0;
    signal            = 4'b0000;
    pos_en            = 4'b0000;
    neg_en            = 4'b0000;
    clr_ovf           = 1'b0;
    evt_bus.evt_ready = 1'b0;
    @(negedge CLK);
    chk("rst valid", 32'(evt_bus.evt_valid), 32'd0);
    chk("rst id", 32'(evt_bus.evt_id), 32'd0);
    chk("rst pol", 32'(evt_bus.evt_pol), 32'd0);
    chk("rst pending", 32'(pending), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);

    do_reset(4'b0000);
    run_rows(0, 4);
    do_reset(4'b0000);
    run_rows(5, 12);

    // backpressure with a dropped falling edge on ch1
    do_reset(4'b0000);
    pos_en = 4'b1111; neg_en = 4'b1111; evt_bus.evt_ready = 1'b0;
    signal = 4'b0010;
    step();
    chk("bp pending", 32'(pending), 32'h2);
    step();
    chk("bp offer valid", 32'(evt_bus.evt_valid), 32'd1);
    chk("bp offer id", 32'(evt_bus.evt_id), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp hold valid", 32'(evt_bus.evt_valid), 32'd1);
    end
    signal = 4'b0000;
    step();
    chk("bp pol kept", 32'(evt_bus.evt_pol), 32'd1);
    chk("bp overflow", 32'(overflow), 32'h2);
    chk("bp pending kept", 32'(pending), 32'h2);
    evt_bus.evt_ready = 1'b1;
    step();
    chk("bp accept valid", 32'(evt_bus.evt_valid), 32'd0);
    chk("bp accept pending", 32'(pending), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp single event", 32'(evt_bus.evt_valid), 32'd0);
    end

    // falling edge on ch0 during the handshake of its rising event
    do_reset(4'b0000);
    pos_en = 4'b1111; neg_en = 4'b1111; evt_bus.evt_ready = 1'b0;
    signal = 4'b0001;
    step();
    step();
    chk("ane offer", 32'(evt_bus.evt_valid), 32'd1);
    chk("ane pol1", 32'(evt_bus.evt_pol), 32'd1);
    evt_bus.evt_ready = 1'b1;
    signal = 4'b0000;
    step();
    chk("ane repend", 32'(pending), 32'h1);
    chk("ane valid gap", 32'(evt_bus.evt_valid), 32'd0);
    chk("ane no ovf", 32'(overflow), 32'd0);
    step();
    chk("ane second valid", 32'(evt_bus.evt_valid), 32'd1);
    chk("ane second id", 32'(evt_bus.evt_id), 32'd0);
    chk("ane second pol", 32'(evt_bus.evt_pol), 32'd0);
    chk("ane ovf", 32'(overflow), 32'd0);
    step();
    chk("ane done pending", 32'(pending), 32'd0);

    // levels high at reset release create no events
    do_reset(4'b1111);
    pos_en = 4'b1111; neg_en = 4'b1111; evt_bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rel valid", 32'(evt_bus.evt_valid), 32'd0);
      chk("rel pending", 32'(pending), 32'd0);
    end
    evt_bus.evt_ready = 1'b0;
    signal = 4'b1110;
    step();
    chk("midrst pend", 32'(pending), 32'h1);
    step();
    chk("midrst offer", 32'(evt_bus.evt_valid), 32'd1);
    nRST = 1'b0;
    #1;
    chk("midrst valid", 32'(evt_bus.evt_valid), 32'd0);
    chk("midrst pending", 32'(pending), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // clr_ovf colliding with a new overflow on ch3
    do_reset(4'b0000);
    pos_en = 4'b1111; neg_en = 4'b1111; evt_bus.evt_ready = 1'b0;
    signal = 4'b0001;
    step();
    signal = 4'b0000;
    step();
    chk("clr pre ovf", 32'(overflow), 32'h1);
    signal = 4'b1000;
    step();
    chk("clr pend", 32'(pending), 32'h9);
    signal = 4'b0000;
    clr_ovf = 1'b1;
    step();
    chk("clr collide", 32'(overflow), 32'h8);
    clr_ovf = 1'b0;
    step();
    chk("clr sticky", 32'(overflow), 32'h8);
    clr_ovf = 1'b1;
    step();
    chk("clr all", 32'(overflow), 32'h0);
    clr_ovf = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
